// File: rtl/rom_load_sched.sv
// Download scheduler: routes data_io bytes through a small FIFO to the two
// toggle-handshake SDRAM write ports or the NVRAM port, and sequences core reset.
module rom_load_sched #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [24:0] GFX_BASE    = 25'h10000,
  parameter logic [7:0]  ROM_INDEX   = 8'h00,
  parameter logic [7:0]  NVRAM_INDEX = 8'hFF,
  parameter int          RESET_HOLD  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        nvram_we,
  output logic [8:0]  nvram_a,
  output logic [7:0]  nvram_d,
  output logic        busy,
  output logic        rom_loaded,
  output logic        overflow,
  output logic        core_reset,
  output logic [1:0]  state_dbg
);

  // Handshake: a port request is outstanding while portn_req != portn_ack; the
  // scheduler toggles req once per word and holds a/ds/d until ack equals req.

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD);

  typedef struct packed {
    logic        nv;
    logic [24:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT1, WAIT2} state_t;

  state_t        state, next_state;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  entry_t        entry_in;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          wr_prev, downl_prev;
  logic          push_req, push, pop, full, empty, is_gfx;
  logic [23:0]   gfx_off;
  logic          done_pending, load_done;
  logic [HW-1:0] hold_cnt;
  logic          dl_rise, dl_fall;

  assign push_req = ioctl_downl & ioctl_wr & ~wr_prev &
                    ((ioctl_index == ROM_INDEX) | (ioctl_index == NVRAM_INDEX));
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop      = (state == DISPATCH);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);
  assign entry_in = '{nv: (ioctl_index == NVRAM_INDEX), addr: ioctl_addr, data: ioctl_dout};
  assign head     = mem[rd_ptr];
  assign is_gfx   = (head.addr >= GFX_BASE);
  assign gfx_off  = 24'(head.addr - GFX_BASE);

  assign busy       = ~empty | (state != IDLE);
  assign core_reset = user_reset | ~rom_loaded | (hold_cnt != '0);
  assign state_dbg  = state;

  assign dl_rise   = ioctl_downl & ~downl_prev;
  assign dl_fall   = ~ioctl_downl & downl_prev;
  assign load_done = done_pending & ~busy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_prev <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      wr_prev <= ioctl_wr;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (!empty) next_state = DISPATCH;
      DISPATCH: begin
        if (head.nv)     next_state = IDLE;
        else if (is_gfx) next_state = WAIT2;
        else             next_state = WAIT1;
      end
      WAIT1:    if (port1_ack == port1_req) next_state = IDLE;
      WAIT2:    if (port2_ack == port2_req) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
      nvram_we  <= 1'b0;
      nvram_a   <= '0;
      nvram_d   <= '0;
    end else begin
      nvram_we <= 1'b0;
      if (state == DISPATCH) begin
        if (head.nv) begin
          nvram_we <= 1'b1;
          nvram_a  <= head.addr[8:0];
          nvram_d  <= head.data;
        end else if (!is_gfx) begin
          port1_a   <= head.addr[23:1];
          port1_ds  <= {head.addr[0], ~head.addr[0]};
          port1_d   <= {2{head.data}};
          port1_req <= ~port1_req;
        end else begin
          port2_a   <= gfx_off[23:1];
          port2_ds  <= {gfx_off[0], ~gfx_off[0]};
          port2_d   <= {2{head.data}};
          port2_req <= ~port2_req;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      downl_prev   <= 1'b0;
      done_pending <= 1'b0;
      rom_loaded   <= 1'b0;
      overflow     <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      downl_prev <= ioctl_downl;
      if (push_req & full & ~pop) overflow <= 1'b1;
      // A new ROM download invalidates any earlier completion.
      if (dl_rise && (ioctl_index == ROM_INDEX)) begin
        rom_loaded   <= 1'b0;
        done_pending <= 1'b0;
      end else begin
        if (load_done) begin
          rom_loaded   <= 1'b1;
          done_pending <= 1'b0;
        end
        if (dl_fall && (ioctl_index == ROM_INDEX)) done_pending <= 1'b1;
      end
      if (load_done && !rom_loaded && !(dl_rise && (ioctl_index == ROM_INDEX)))
        hold_cnt <= HOLD_INIT;
      else if (hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

endmodule

// File: doc/rom_load_sched.md
Name: rom_load_sched

Overview:
Sequences the data_io download byte stream into the two toggle-handshake SDRAM write ports (program ROM / graphics ROM) and the NVRAM write port, with a small byte FIFO to absorb SDRAM latency. Also generates the loaded flag and the core reset hold. Sits in the clk_sd domain between data_io, sdram and the core NVRAM port.

Parameters:
FIFO_DEPTH, 4, byte FIFO entries (power of 2, >=2)
GFX_BASE, 25'h10000, first byte address routed to port2; port2 address = byte_addr - GFX_BASE
ROM_INDEX, 8'h00, ioctl_index value for ROM download
NVRAM_INDEX, 8'hFF, ioctl_index value for NVRAM download
RESET_HOLD, 16, clk cycles core_reset stays high after rom_loaded rises

Ports:
clk  in  1  SDRAM clock (clk_sd)
reset_n  in  1  synchronous active-low reset
ioctl_downl  in  1  download active
ioctl_index  in  8  download target index
ioctl_wr  in  1  byte strobe (may stay high >1 cycle)
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
user_reset  in  1  OR of status[0]/button reset
port1_req  out  1  toggle request, program ROM
port1_ack  in  1  toggle ack, program ROM
port1_a  out  23  word address
port1_ds  out  2  byte selects {hi,lo}
port1_d  out  16  write data (byte duplicated)
port2_req/port2_ack/port2_a/port2_ds/port2_d  same as port1, graphics ROM
nvram_we  out  1  one-cycle NVRAM write strobe
nvram_a  out  9  NVRAM address
nvram_d  out  8  NVRAM data
busy  out  1  FIFO non-empty or handshake pending
rom_loaded  out  1  sticky: ROM download completed and drained
overflow  out  1  sticky: byte dropped on full FIFO
core_reset  out  1  active-high core reset

Behaviour:
- Reset (reset_n=0 at clk edge): port1_req=port2_req=0, all *_a/_ds/_d=0, nvram_we=0, FIFO empty, busy=0, rom_loaded=0, overflow=0, core_reset=1, state IDLE. Reset mid-transfer abandons the pending request; sdram ack is assumed realigned by sdram's own reset.
- Capture: rising edge of ioctl_wr (registered previous value) while ioctl_downl=1 and index in {ROM_INDEX, NVRAM_INDEX} pushes {index==NVRAM_INDEX, addr, dout}. Other indices ignored. Push on full FIFO: byte dropped, overflow<=1.
- FIFO: first-word fall-through, simultaneous push and pop allowed when full (pop frees slot same cycle).
- Scheduler FSM: IDLE -> DISPATCH when FIFO non-empty. DISPATCH: pop head; NVRAM entry: nvram_we=1 one cycle with a=addr[8:0], d=dout, back to IDLE (1 cycle/byte). ROM entry with addr<GFX_BASE: drive port1_a=addr[23:1], ds={addr[0],~addr[0]}, d={dout,dout}, toggle port1_req, go WAIT1. Else same on port2 with (addr-GFX_BASE), go WAIT2. WAITn -> IDLE when portn_ack==portn_req. Address/data held stable from toggle until ack matches.
- Only one outstanding request total; ports never toggled simultaneously.
- busy = FIFO non-empty or state!=IDLE.
- Completion: on falling edge of ioctl_downl for a ROM_INDEX download, set done_pending; rom_loaded<=1 on the first cycle done_pending=1 and busy=0. NVRAM download end does not affect rom_loaded.
- core_reset = user_reset | ~rom_loaded | hold_cnt!=0; hold_cnt loads RESET_HOLD when rom_loaded rises, decrements to 0. New ROM download (ioctl_downl rising, ROM_INDEX) clears rom_loaded.
- Latency: ioctl_wr rise -> request toggle 3 clk when idle (edge reg, push, dispatch).

Test Plan:
- Reset: reset_n=0 2 cycles -> core_reset=1, req=0, rom_loaded=0, busy=0.
- ROM bytes addr 0x00000=0xA5, 0x00001=0x5A, ack after 4 cycles -> port1 toggles twice, a=0, ds=01 then 10, d=A5A5 then 5A5A; port2 untouched.
- Byte addr GFX_BASE+3=0x77 -> port2_a=1, ds=10, d=7777; port1 untouched.
- Ack withheld, 6 strobes -> 1 in flight + 4 queued, 6th sets overflow=1; release ack -> 5 writes complete in order.
- Index 0xFF bytes addr 0x1FF=0x42 -> nvram_we one cycle, a=0x1FF, d=0x42; no SDRAM req; rom_loaded unchanged.
- ioctl_downl falls with 2 bytes pending -> rom_loaded rises only after last ack; core_reset falls exactly RESET_HOLD cycles later with user_reset=0.
